ripple_capture: RTL

Downstream consumer for the ripple counter's asynchronous multi-bit count. It synchronizes the count into the `clk` domain and rejects ripple-settling glitches with a stability filter. Each accepted value's modular delta is accumulated into a wide total, which is presented on a valid/ready output port with a sticky overflow flag.

---
 rtl/ripple_capture.sv | 109 ++++++++++
 1 files changed

// File: rtl/ripple_capture.sv
`timescale 1ns/1ps
// ripple_capture: synchronizes an asynchronous ripple count, filters settling glitches,
// and accumulates modular deltas into a wide total delivered over valid/ready.
module ripple_capture #(
    parameter int CNT_W    = 4,
    parameter int ACC_W    = 16,
    parameter int STABLE_N = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [CNT_W-1:0] cnt_in,
    input  logic             count_dir,
    input  logic             clr,
    output logic [ACC_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             ovf
);

    typedef enum logic {ST_INIT, ST_TRACK} state_t;

    localparam logic [3:0] RUN_MAX = 4'(STABLE_N);

    logic [CNT_W-1:0] s1, s2;
    logic [CNT_W-1:0] cand, last, delta;
    logic [3:0]       run, run_nxt;
    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   sum;
    logic             pend, accept, load;
    state_t           state;

    // NOTE: every variable driven here gets a default first, so no latch is inferred.
    always_comb begin
        run_nxt = run;
        accept  = 1'b0;
        if (s2 == cand) begin
            run_nxt = (run >= RUN_MAX) ? RUN_MAX : run + 4'd1;
            accept  = (run != RUN_MAX) && (run_nxt == RUN_MAX);
        end else begin
            run_nxt = 4'd1;
            accept  = (RUN_MAX == 4'd1);
        end
        // On an accept s2 equals the value being accepted (cand or its replacement).
        delta = count_dir ? (last - s2) : (s2 - last);
        sum   = {1'b0, acc} + {{(ACC_W + 1 - CNT_W){1'b0}}, delta};
        load  = pend && (!out_valid || out_ready);
    end

    // Two-flop synchronizer; clr deliberately leaves it running.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= cnt_in;
            s2 <= s1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cand      <= '0;
            last      <= '0;
            run       <= '0;
            acc       <= '0;
            ovf       <= 1'b0;
            pend      <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            state     <= ST_INIT;
        end else begin
            cand <= s2;
            if (clr) begin
                run       <= '0;
                acc       <= '0;
                ovf       <= 1'b0;
                pend      <= 1'b0;
                out_valid <= 1'b0;
                state     <= ST_INIT;
            end else begin
                run <= run_nxt;

                // Output slot sees the acc/pend present before this edge's accept.
                if (load) begin
                    out_data  <= acc;
                    out_valid <= 1'b1;
                    pend      <= 1'b0;
                end else if (out_valid && out_ready) begin
                    out_valid <= 1'b0;
                end

                if (accept) begin
                    last <= s2;
                    if (state == ST_INIT) begin
                        state <= ST_TRACK;
                    end else begin
                        acc <= sum[ACC_W-1:0];
                        if (sum[ACC_W])
                            ovf <= 1'b1;
                        if (delta != '0)
                            pend <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
